decode_scoreboard: RTL and testbench



---
 rtl/decode_scoreboard_if.sv | 37 +++
 rtl/decode_scoreboard.sv | 115 +++++++++++
 tb/tb_decode_scoreboard.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_scoreboard_if.sv
// Handshake bundle between Decode and the issue scoreboard.
// Signal suffixes are relative to the scoreboard (slave) side.
interface decode_scoreboard_if #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 8
);
    logic                       enable_i;
    logic                       flushBack_i;
    logic [1:0]                 functionType_i;
    logic [REG_ADDR_WIDTH-1:0]  primOperand_i;
    logic [15:0]                secOperand_i;
    logic                       pRead_i;
    logic                       pWrite_i;
    logic                       sRead_i;
    logic                       writebackEnable_i;
    logic [REG_ADDR_WIDTH-1:0]  writebackReg_i;
    logic                       branchResolved_i;
    logic                       shouldStall_o;
    logic                       issue_o;
    logic [REG_ADDR_WIDTH:0]    pendingCount_o;
    logic [STALL_CNT_WIDTH-1:0] stallCount_o;
    logic                       branchPending_o;

    modport master (
        output enable_i, flushBack_i, functionType_i, primOperand_i, secOperand_i,
               pRead_i, pWrite_i, sRead_i, writebackEnable_i, writebackReg_i,
               branchResolved_i,
        input  shouldStall_o, issue_o, pendingCount_o, stallCount_o, branchPending_o
    );

    modport slave (
        input  enable_i, flushBack_i, functionType_i, primOperand_i, secOperand_i,
               pRead_i, pWrite_i, sRead_i, writebackEnable_i, writebackReg_i,
               branchResolved_i,
        output shouldStall_o, issue_o, pendingCount_o, stallCount_o, branchPending_o
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Issue scoreboard: tracks in-flight primary writes, stalls Decode on register
// hazards and while a branch is unresolved, and keeps occupancy/stall statistics.
module decode_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    decode_scoreboard_if.slave bus
);
    typedef enum logic {RUN, BRANCH} state_t;

    localparam logic [REG_ADDR_WIDTH:0]    PCNT_ONE  = 1;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;

    state_t                     r_state;
    logic [NUM_REGS-1:0]        r_pending;
    logic [REG_ADDR_WIDTH:0]    r_pendingCount;
    logic [STALL_CNT_WIDTH-1:0] r_stallCount;

    logic [REG_ADDR_WIDTH-1:0]  w_secIdx;
    logic                       w_primValid;
    logic                       w_secValid;
    logic                       w_wbValid;
    logic                       w_primPending;
    logic                       w_secPending;
    logic                       w_hazard;
    logic                       w_active;
    logic                       w_stall;
    logic                       w_issue;
    logic                       w_setEn;
    logic                       w_clrEn;
    logic                       w_setHit;
    logic                       w_clrHit;
    logic [NUM_REGS-1:0]        w_setMask;
    logic [NUM_REGS-1:0]        w_clrMask;
    logic                       w_unusedSecBits;

    assign w_secIdx        = bus.secOperand_i[REG_ADDR_WIDTH-1:0];
    assign w_unusedSecBits = ^bus.secOperand_i[15:REG_ADDR_WIDTH];

    // Indices beyond the tracked register file never hazard and are never recorded.
    assign w_primValid = 32'(bus.primOperand_i)  < 32'(NUM_REGS);
    assign w_secValid  = 32'(w_secIdx)           < 32'(NUM_REGS);
    assign w_wbValid   = 32'(bus.writebackReg_i) < 32'(NUM_REGS);

    assign w_primPending = w_primValid && r_pending[bus.primOperand_i];
    assign w_secPending  = w_secValid  && r_pending[w_secIdx];
    assign w_hazard      = ((bus.pRead_i || bus.pWrite_i) && w_primPending)
                         || (bus.sRead_i && w_secPending);

    assign w_active = !reset_i && bus.enable_i && !bus.flushBack_i;
    assign w_stall  = w_active && (w_hazard || (r_state == BRANCH));
    assign w_issue  = w_active && !w_stall;

    assign w_setEn  = w_issue && bus.pWrite_i && w_primValid;
    assign w_clrEn  = bus.writebackEnable_i && w_wbValid;
    assign w_setHit = w_setEn && !r_pending[bus.primOperand_i];
    // A clear of the index being set this cycle is overridden, so it must not count.
    assign w_clrHit = w_clrEn && r_pending[bus.writebackReg_i]
                   && !(w_setEn && (bus.primOperand_i == bus.writebackReg_i));

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_setMask[i] = w_setEn && (32'(bus.primOperand_i)  == 32'(i));
            w_clrMask[i] = w_clrEn && (32'(bus.writebackReg_i) == 32'(i));
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state        <= RUN;
            r_pending      <= '0;
            r_pendingCount <= '0;
            r_stallCount   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clrMask) | w_setMask;

            if (w_setHit && !w_clrHit) begin
                r_pendingCount <= r_pendingCount + PCNT_ONE;
            end else if (w_clrHit && !w_setHit) begin
                r_pendingCount <= r_pendingCount - PCNT_ONE;
            end

            if (!w_stall) begin
                r_stallCount <= '0;
            end else if (r_stallCount != '1) begin
                r_stallCount <= r_stallCount + STALL_ONE;
            end

            case (r_state)
                RUN: begin
                    if (w_issue && (bus.functionType_i == 2'd2)) begin
                        r_state <= BRANCH;
                    end
                end
                BRANCH: begin
                    if (bus.branchResolved_i || bus.flushBack_i) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.shouldStall_o   = w_stall;
    assign bus.issue_o         = w_issue;
    assign bus.pendingCount_o  = r_pendingCount;
    assign bus.stallCount_o    = r_stallCount;
    assign bus.branchPending_o = (r_state == BRANCH);
endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench: two scoreboard instances (full-size, and a reduced one with
// 24 registers and a 2-bit stall counter) checked against a behavioural model.
module tb_decode_scoreboard;
    logic clock = 1'b0;
    logic resetSig;

    always #5 clock = ~clock;

    decode_scoreboard_if #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(8)) ifA ();
    decode_scoreboard_if #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(2)) ifB ();

    decode_scoreboard #(.NUM_REGS(32), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(8)) dutA (
        .clock_i(clock),
        .reset_i(resetSig),
        .bus    (ifA.slave)
    );

    decode_scoreboard #(.NUM_REGS(24), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(2)) dutB (
        .clock_i(clock),
        .reset_i(resetSig),
        .bus    (ifB.slave)
    );

    // The reduced instance sees exactly the same stimulus.
    assign ifB.enable_i          = ifA.enable_i;
    assign ifB.flushBack_i       = ifA.flushBack_i;
    assign ifB.functionType_i    = ifA.functionType_i;
    assign ifB.primOperand_i     = ifA.primOperand_i;
    assign ifB.secOperand_i      = ifA.secOperand_i;
    assign ifB.pRead_i           = ifA.pRead_i;
    assign ifB.pWrite_i          = ifA.pWrite_i;
    assign ifB.sRead_i           = ifA.sRead_i;
    assign ifB.writebackEnable_i = ifA.writebackEnable_i;
    assign ifB.writebackReg_i    = ifA.writebackReg_i;
    assign ifB.branchResolved_i  = ifA.branchResolved_i;

    typedef struct {
        bit regsValid;
        bit stall;
        bit issue;
        int pendCnt;
        int stallCnt;
        bit branchPend;
    } entry_t;

    entry_t qA[$];
    entry_t qB[$];

    int vectorCount     = 0;
    int miscompareCount = 0;

    // Stimulus for the current cycle
    bit        sRst, sEn, sFlush, sPR, sPW, sSR, sWbEn, sBr;
    bit [1:0]  sFt;
    bit [4:0]  sPrim, sWbReg;
    bit [15:0] sSec;

    // Reference model state, one slot per instance
    bit mPend [2][32];
    bit mBranch [2];
    int mStall [2];
    bit mValid = 1'b0;
    int numRegs [2] = '{32, 24};
    int satMax  [2] = '{255, 3};

    task automatic modelStep(input int k);
        entry_t e;
        int     cnt;
        int     sIdx;
        bit     hazard;
        cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(mPend[k][r]);
        e.regsValid  = mValid;
        e.pendCnt    = cnt;
        e.stallCnt   = mStall[k];
        e.branchPend = mBranch[k];
        if (sRst) begin
            e.stall = 1'b0;
            e.issue = 1'b0;
            for (int r = 0; r < 32; r++) mPend[k][r] = 1'b0;
            mBranch[k] = 1'b0;
            mStall[k]  = 0;
        end else begin
            sIdx   = int'(sSec[4:0]);
            hazard = ((sPR || sPW) && int'(sPrim) < numRegs[k] && mPend[k][sPrim])
                  || (sSR && sIdx < numRegs[k] && mPend[k][sIdx]);
            e.stall = sEn && !sFlush && (hazard || mBranch[k]);
            e.issue = sEn && !sFlush && !e.stall;
            if (sWbEn && int'(sWbReg) < numRegs[k]) mPend[k][sWbReg] = 1'b0;
            if (e.issue && sPW && int'(sPrim) < numRegs[k]) mPend[k][sPrim] = 1'b1;
            if (mBranch[k]) begin
                if (sBr || sFlush) mBranch[k] = 1'b0;
            end else if (e.issue && sFt == 2'd2) begin
                mBranch[k] = 1'b1;
            end
            mStall[k] = e.stall ? ((mStall[k] + 1 > satMax[k]) ? satMax[k] : mStall[k] + 1) : 0;
        end
        if (k == 0) qA.push_back(e);
        else        qB.push_back(e);
    endtask

    task automatic applyStimulus();
        @(posedge clock);
        #1;
        resetSig              = sRst;
        ifA.enable_i          = sEn;
        ifA.flushBack_i       = sFlush;
        ifA.functionType_i    = sFt;
        ifA.primOperand_i     = sPrim;
        ifA.secOperand_i      = sSec;
        ifA.pRead_i           = sPR;
        ifA.pWrite_i          = sPW;
        ifA.sRead_i           = sSR;
        ifA.writebackEnable_i = sWbEn;
        ifA.writebackReg_i    = sWbReg;
        ifA.branchResolved_i  = sBr;
        modelStep(0);
        modelStep(1);
        if (sRst) mValid = 1'b1;
    endtask

    task automatic clearInputs();
        sRst = 0; sEn = 0; sFlush = 0; sFt = 0; sPrim = 0; sSec = 0;
        sPR = 0; sPW = 0; sSR = 0; sWbEn = 0; sWbReg = 0; sBr = 0;
    endtask

    task automatic instr(input bit [1:0] ft, input bit [4:0] prim, input bit pr, input bit pw,
                         input bit sr, input bit [15:0] sec, input int cycles);
        clearInputs();
        sEn = 1; sFt = ft; sPrim = prim; sPR = pr; sPW = pw; sSR = sr; sSec = sec;
        repeat (cycles) applyStimulus();
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input int k, input entry_t e);
        string tag;
        logic        stall, issue, bpend;
        logic [31:0] pcnt, scnt;
        tag = (k == 0) ? "A" : "B";
        if (k == 0) begin
            stall = ifA.shouldStall_o; issue = ifA.issue_o; bpend = ifA.branchPending_o;
            pcnt = 32'(ifA.pendingCount_o); scnt = 32'(ifA.stallCount_o);
        end else begin
            stall = ifB.shouldStall_o; issue = ifB.issue_o; bpend = ifB.branchPending_o;
            pcnt = 32'(ifB.pendingCount_o); scnt = 32'(ifB.stallCount_o);
        end
        checkValue({tag, ".shouldStall"}, 32'(stall), 32'(e.stall));
        checkValue({tag, ".issue"}, 32'(issue), 32'(e.issue));
        if (e.regsValid) begin
            checkValue({tag, ".pendingCount"}, pcnt, 32'(e.pendCnt));
            checkValue({tag, ".stallCount"}, scnt, 32'(e.stallCnt));
            checkValue({tag, ".branchPending"}, 32'(bpend), 32'(e.branchPend));
        end
    endtask

    // Monitor: mid-cycle, pop whatever the stimulus side predicted and compare.
    initial begin
        entry_t e;
        forever begin
            @(negedge clock);
            if (qA.size() > 0) begin
                e = qA.pop_front();
                checkOutput(0, e);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                checkOutput(1, e);
            end
        end
    end

    initial begin
        clearInputs();
        resetSig = 1'b1;
        ifA.enable_i = 0; ifA.flushBack_i = 0; ifA.functionType_i = 0; ifA.primOperand_i = 0;
        ifA.secOperand_i = 0; ifA.pRead_i = 0; ifA.pWrite_i = 0; ifA.sRead_i = 0;
        ifA.writebackEnable_i = 0; ifA.writebackReg_i = 0; ifA.branchResolved_i = 0;

        sRst = 1;
        repeat (2) applyStimulus();

        // RAW on r5, writeback still stalls its own cycle
        instr(2'd0, 5'd5, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd5, 1, 0, 0, 16'h0, 3);
        sWbEn = 1; sWbReg = 5; applyStimulus();
        sWbEn = 0; applyStimulus();
        clearInputs(); applyStimulus();

        // Secondary-operand hazard on r7
        instr(2'd0, 5'd7, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd0, 0, 0, 1, 16'h0007, 2);
        instr(2'd0, 5'd0, 0, 0, 0, 16'h0007, 1);
        clearInputs(); sWbEn = 1; sWbReg = 7; applyStimulus();

        // Branch serialisation
        instr(2'd2, 5'd0, 0, 0, 0, 16'h0, 1);
        instr(2'd0, 5'd1, 1, 0, 0, 16'h0, 3);
        sBr = 1; applyStimulus();
        sBr = 0; applyStimulus();

        // Set and clear of r3 colliding
        instr(2'd0, 5'd3, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd3, 0, 1, 0, 16'h0, 1);
        sWbEn = 1; sWbReg = 3; applyStimulus();
        sWbEn = 1; sWbReg = 3; applyStimulus();
        instr(2'd0, 5'd6, 0, 1, 0, 16'h0, 1);
        sWbEn = 1; sWbReg = 3; applyStimulus();

        // Flush during BRANCH with r9 pending, then reset during a stall
        instr(2'd0, 5'd9, 0, 1, 0, 16'h0, 1);
        instr(2'd2, 5'd0, 0, 0, 0, 16'h0, 1);
        instr(2'd0, 5'd1, 0, 0, 0, 16'h0, 1);
        sFlush = 1; applyStimulus();
        instr(2'd0, 5'd1, 0, 0, 0, 16'h0, 1);
        instr(2'd0, 5'd9, 1, 0, 0, 16'h0, 3);
        sRst = 1; applyStimulus();
        sRst = 0; applyStimulus();
        clearInputs(); applyStimulus();

        // Long hazard: saturates both stall counters
        instr(2'd0, 5'd4, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd4, 1, 0, 0, 16'h0, 260);
        clearInputs(); sWbEn = 1; sWbReg = 4; applyStimulus();

        // Index beyond the reduced register file
        instr(2'd0, 5'd28, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd28, 1, 0, 0, 16'h0, 2);
        instr(2'd0, 5'd0, 0, 0, 1, 16'h001C, 2);
        clearInputs(); sWbEn = 1; sWbReg = 28; applyStimulus();

        // Register 0 is an ordinary register
        instr(2'd0, 5'd0, 0, 1, 0, 16'h0, 1);
        instr(2'd0, 5'd0, 1, 0, 0, 16'h0, 2);
        clearInputs(); sWbEn = 1; sWbReg = 0; applyStimulus();

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            sRst   = ($urandom % 250) == 0;
            sEn    = ($urandom % 4) != 0;
            sFlush = ($urandom % 16) == 0;
            sFt    = 2'($urandom);
            sPrim  = 5'($urandom);
            sSec   = 16'($urandom);
            sPR    = 1'($urandom);
            sPW    = 1'($urandom);
            sSR    = 1'($urandom);
            sWbEn  = ($urandom % 3) != 0;
            sWbReg = 5'($urandom);
            sBr    = ($urandom % 5) == 0;
            applyStimulus();
        end

        clearInputs();
        repeat (2) @(posedge clock);
        vectorCount++;
        if (qA.size() != 0 || qB.size() != 0) begin
            miscompareCount++;
            $display("[TB] FAIL drain: got %0d entries left, expected 0", qA.size() + qB.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end
endmodule
